ddr_rw_arbiter: RTL

- Shares the single DDR user-interface command port (wr_en/rd_en, 25-bit address, 256-bit data) between two requesters.
  - Write requester: the 8-to-256 packet packer, which stores incoming redundant packet copies.
  - Read requester: the majority voter, which fetches stored copies of a segment to vote on them.
- Sits in the ui_clk domain, between the async-FIFO outputs and the memory controller wrapper.
- Arbitrates round-robin with bounded bursts, limits outstanding reads, and returns read data in order.

---
 rtl/ddr_rw_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/ddr_rw_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_rw_arbiter
// Shares the single DDR user-interface command port between the packet packer
// (write requester) and the majority voter (read requester). Grants alternate
// round-robin through a one-cycle IDLE bubble. A side is forced off the port
// after MAX_BURST accepted commands while the other side waits. Reads in flight
// are limited to MAX_OUTSTANDING, and read data comes back registered and in
// order.
//
// Ports (all in the ui_clk domain):
//   ui_clk, RST                   clock, asynchronous active-low reset
//   wq_valid/wq_ready             write request handshake
//   wq_addr/wq_data               write request payload
//   wq_urgent                     write FIFO almost full, forces write priority
//   rq_valid/rq_ready/rq_addr     read request handshake and address
//   rs_valid/rs_data              read response, one cycle after DDR returns it
//   wr_en/wr_addr/wr_data/wr_busy DDR write command port
//   rd_en/rd_addr/rd_busy         DDR read command port
//   rd_data/rd_data_valid         DDR read return
//   rd_overflow                   sticky flag: read data arrived with none in flight
// ---------------------------------------------------------------------------
module ddr_rw_arbiter #(
   parameter int MAX_BURST       = 8,
   parameter int MAX_OUTSTANDING = 4,
   parameter int ADDR_W          = 25,
   parameter int DATA_W          = 256
) (
   input  logic              ui_clk,
   input  logic              RST,
   input  logic              wq_valid,
   output logic              wq_ready,
   input  logic [ADDR_W-1:0] wq_addr,
   input  logic [DATA_W-1:0] wq_data,
   input  logic              wq_urgent,
   input  logic              rq_valid,
   output logic              rq_ready,
   input  logic [ADDR_W-1:0] rq_addr,
   output logic              rs_valid,
   output logic [DATA_W-1:0] rs_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   input  logic              wr_busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_busy,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              rd_data_valid,
   output logic              rd_overflow
);

   localparam int BURST_W = $clog2(MAX_BURST + 1);
   localparam int OUTST_W = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_nextState;
   logic                 r_lastGrantRd;
   logic                 w_nextLastGrantRd;
   logic [BURST_W-1:0]   r_burstCnt;
   logic [BURST_W-1:0]   w_nextBurstCnt;
   logic [BURST_W-1:0]   w_burstInc;
   logic [BURST_W-1:0]   w_burstAfter;
   logic                 w_burstDone;
   logic [OUTST_W-1:0]   r_outst;
   logic                 w_rdElig;
   logic                 w_wrElig;
   logic                 w_rdAccept;
   logic                 w_wrAccept;

   // Command port handshakes. The busy inputs are already folded into the
   // ready terms, so wr_en/rd_en high means the command is accepted.
   assign w_rdElig   = rq_valid & (r_outst < OUTST_W'(MAX_OUTSTANDING));
   assign w_wrElig   = wq_valid;
   assign wq_ready   = (r_state == WR) & ~wr_busy;
   assign rq_ready   = (r_state == RD) & ~rd_busy & (r_outst < OUTST_W'(MAX_OUTSTANDING));
   assign wr_en      = wq_valid & wq_ready;
   assign rd_en      = rq_valid & rq_ready;
   assign wr_addr    = wq_addr;
   assign wr_data    = wq_data;
   assign rd_addr    = rq_addr;
   assign w_wrAccept = wr_en;
   assign w_rdAccept = rd_en;

   // Burst count including this cycle's accept, so a side leaves right after
   // its MAX_BURST-th command instead of sneaking in one more.
   assign w_burstInc   = (r_burstCnt == BURST_W'(MAX_BURST)) ? r_burstCnt
                                                              : r_burstCnt + BURST_W'(1);
   assign w_burstAfter = (w_wrAccept | w_rdAccept) ? w_burstInc : r_burstCnt;
   assign w_burstDone  = (w_burstAfter == BURST_W'(MAX_BURST));

   // State, burst counter and round-robin pointer registers.
   always_ff @(posedge ui_clk or negedge RST) begin
      if (!RST) begin
         r_state       <= IDLE;
         r_burstCnt    <= '0;
         r_lastGrantRd <= 1'b1;
      end else begin
         r_state       <= w_nextState;
         r_burstCnt    <= w_nextBurstCnt;
         r_lastGrantRd <= w_nextLastGrantRd;
      end
   end

   // Grant selection. From IDLE a write wins when urgent, when it is alone, or
   // when reads had the last grant; otherwise an eligible read wins. Every
   // grant change passes through IDLE, which gives the one-cycle bubble.
   always_comb begin
      w_nextState       = r_state;
      w_nextBurstCnt    = w_burstAfter;
      w_nextLastGrantRd = r_lastGrantRd;
      case (r_state)
         IDLE: begin
            w_nextBurstCnt = '0;
            if (w_wrElig && (wq_urgent || !w_rdElig || r_lastGrantRd)) begin
               w_nextState       = WR;
               w_nextLastGrantRd = 1'b0;
            end else if (w_rdElig) begin
               w_nextState       = RD;
               w_nextLastGrantRd = 1'b1;
            end
         end
         WR: begin
            if (!wq_valid || (w_burstDone && w_rdElig && !wq_urgent)) begin
               w_nextState = IDLE;
            end
         end
         RD: begin
            if (!w_rdElig || (w_burstDone && w_wrElig) || wq_urgent) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Reads in flight. An accept and a return in the same cycle cancel out.
   // A lone return with nothing in flight cannot belong to any of our reads,
   // so it is flagged and the counter is kept from wrapping.
   always_ff @(posedge ui_clk or negedge RST) begin
      if (!RST) begin
         r_outst     <= '0;
         rd_overflow <= 1'b0;
      end else begin
         case ({w_rdAccept, rd_data_valid})
            2'b10: r_outst <= r_outst + OUTST_W'(1);
            2'b01: begin
               if (r_outst == '0) begin
                  rd_overflow <= 1'b1;
               end else begin
                  r_outst <= r_outst - OUTST_W'(1);
               end
            end
            default: r_outst <= r_outst;
         endcase
      end
   end

   // Read response: a straight one-cycle register of the DDR return.
   always_ff @(posedge ui_clk or negedge RST) begin
      if (!RST) begin
         rs_valid <= 1'b0;
         rs_data  <= '0;
      end else begin
         rs_valid <= rd_data_valid;
         rs_data  <= rd_data;
      end
   end

endmodule
